// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one memory port between fetch and data requesters
//
// Flat struct layouts (MSB first):
//   read  request  [33:0] : {addr[31:0], size[1:0]}
//   read  response [32:0] : {data[31:0], done}
//   write request  [66:0] : {addr[31:0], size[1:0], data[31:0], en}
//   write response [0:0]  : {done}

module mem_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_WIDTH      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_rd_valid,
  input  logic [33:0] if_rd_req,
  output logic [32:0] if_rd_rsp,
  input  logic        dm_rd_valid,
  input  logic [33:0] dm_rd_req,
  output logic [32:0] dm_rd_rsp,
  input  logic [66:0] dm_wr_req,
  output logic        dm_wr_rsp,
  output logic [33:0] mem_rd_req,
  output logic        mem_rd_valid,
  input  logic [32:0] mem_rd_rsp,
  output logic [66:0] mem_wr_req,
  input  logic        mem_wr_rsp,
  output logic        timeout_err,
  output logic        busy
);

  // Watchdog fires in the TIMEOUT_CYCLES-th busy cycle: the counter holds the
  // number of busy cycles already completed, so it reads TIMEOUT_CYCLES-1 then.
  localparam logic                 WD_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_WIDTH-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ?
                                             CNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

  // Response returned to the granted requester when the watchdog aborts.
  localparam logic [32:0] RD_RSP_ABORT = 33'h1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IF_RD = 2'd1,
    DM_RD = 2'd2,
    DM_WR = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  // last_grant_data = 1 means the data requester won the previous arbitration.
  logic                 last_grant_data;
  logic [33:0]          rd_req_q;
  logic [66:0]          wr_req_q;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 err_q;

  logic dm_wr_en;
  logic data_pend;
  logic pick_if;
  logic pick_dm;
  logic mem_rd_done;
  logic timeout_hit;
  logic abort;

  assign dm_wr_en    = dm_wr_req[0];
  assign data_pend   = dm_wr_en | dm_rd_valid;
  assign mem_rd_done = mem_rd_rsp[0];

  // Round-robin: fetch wins alone, or on a tie when data had the last grant.
  assign pick_if = if_rd_valid & (~data_pend | last_grant_data);
  assign pick_dm = data_pend & ~pick_if;

  assign timeout_hit = WD_EN & (cnt == TO_LAST);

  assign busy        = (state != IDLE);
  assign timeout_err = err_q;

  // State register; reset abandons any outstanding transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, downstream request drive and response gating.
  always_comb begin
    state_next   = state;
    if_rd_rsp    = '0;
    dm_rd_rsp    = '0;
    dm_wr_rsp    = 1'b0;
    mem_rd_valid = 1'b0;
    mem_rd_req   = '0;
    mem_wr_req   = '0;
    abort        = 1'b0;
    case (state)
      IDLE: begin
        if (pick_if) begin
          state_next = IF_RD;
        end else if (pick_dm) begin
          // Write takes precedence inside the data requester; the read waits.
          state_next = dm_wr_en ? DM_WR : DM_RD;
        end
      end
      IF_RD: begin
        mem_rd_valid = 1'b1;
        mem_rd_req   = rd_req_q;
        if (mem_rd_done) begin
          if_rd_rsp  = mem_rd_rsp;
          state_next = IDLE;
        end else if (timeout_hit) begin
          if_rd_rsp  = RD_RSP_ABORT;
          abort      = 1'b1;
          state_next = IDLE;
        end
      end
      DM_RD: begin
        mem_rd_valid = 1'b1;
        mem_rd_req   = rd_req_q;
        if (mem_rd_done) begin
          dm_rd_rsp  = mem_rd_rsp;
          state_next = IDLE;
        end else if (timeout_hit) begin
          dm_rd_rsp  = RD_RSP_ABORT;
          abort      = 1'b1;
          state_next = IDLE;
        end
      end
      DM_WR: begin
        mem_wr_req = {wr_req_q[66:1], 1'b1};
        if (mem_wr_rsp) begin
          dm_wr_rsp  = 1'b1;
          state_next = IDLE;
        end else if (timeout_hit) begin
          dm_wr_rsp  = 1'b1;
          abort      = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Capture the granted request at the grant edge and remember the winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_req_q        <= '0;
      wr_req_q        <= '0;
      last_grant_data <= 1'b1;
    end else if (state == IDLE) begin
      if (pick_if) begin
        rd_req_q        <= if_rd_req;
        last_grant_data <= 1'b0;
      end else if (pick_dm) begin
        last_grant_data <= 1'b1;
        if (dm_wr_en) begin
          wr_req_q <= dm_wr_req;
        end else begin
          rd_req_q <= dm_rd_req;
        end
      end
    end
  end

  // Watchdog counter: held at zero while idle, counts busy cycles otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state == IDLE) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_WIDTH'(1);
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (abort) begin
      err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_rd_valid;
  logic [33:0] if_rd_req;
  logic [32:0] if_rd_rsp;
  logic        dm_rd_valid;
  logic [33:0] dm_rd_req;
  logic [32:0] dm_rd_rsp;
  logic [66:0] dm_wr_req;
  logic        dm_wr_rsp;
  logic [33:0] mem_rd_req;
  logic        mem_rd_valid;
  logic [32:0] mem_rd_rsp;
  logic [66:0] mem_wr_req;
  logic        mem_wr_rsp;
  logic        timeout_err;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .TIMEOUT_CYCLES(4),
    .CNT_WIDTH(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .if_rd_valid(if_rd_valid),
    .if_rd_req(if_rd_req),
    .if_rd_rsp(if_rd_rsp),
    .dm_rd_valid(dm_rd_valid),
    .dm_rd_req(dm_rd_req),
    .dm_rd_rsp(dm_rd_rsp),
    .dm_wr_req(dm_wr_req),
    .dm_wr_rsp(dm_wr_rsp),
    .mem_rd_req(mem_rd_req),
    .mem_rd_valid(mem_rd_valid),
    .mem_rd_rsp(mem_rd_rsp),
    .mem_wr_req(mem_wr_req),
    .mem_wr_rsp(mem_wr_rsp),
    .timeout_err(timeout_err),
    .busy(busy)
  );

  task automatic clear_inputs();
    if_rd_valid = 1'b0;
    if_rd_req   = '0;
    dm_rd_valid = 1'b0;
    dm_rd_req   = '0;
    dm_wr_req   = '0;
    mem_rd_rsp  = '0;
    mem_wr_rsp  = 1'b0;
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    step();
    // Requests and spurious responses while in reset must not leak through.
    if_rd_valid = 1'b1;
    if_rd_req   = {32'h0000_0800, 2'd2};
    mem_rd_rsp  = {32'hFFFF_FFFF, 1'b1};
    mem_wr_rsp  = 1'b1;
    step();
    #1;
    if (busy !== 1'b0) $display("FAIL reset_busy got=%0h exp=0", busy); else n_pass++;
    n_checks++;
    if (timeout_err !== 1'b0) $display("FAIL reset_timeout_err got=%0h exp=0", timeout_err); else n_pass++;
    n_checks++;
    if ({mem_rd_valid, mem_rd_req} !== 35'h0) $display("FAIL reset_mem_rd got=%0h exp=0", {mem_rd_valid, mem_rd_req}); else n_pass++;
    n_checks++;
    if (mem_wr_req !== 67'h0) $display("FAIL reset_mem_wr got=%0h exp=0", mem_wr_req); else n_pass++;
    n_checks++;
    if ({if_rd_rsp, dm_rd_rsp, dm_wr_rsp} !== 67'h0) $display("FAIL reset_rsps got=%0h exp=0", {if_rd_rsp, dm_rd_rsp, dm_wr_rsp}); else n_pass++;
    n_checks++;
    clear_inputs();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_fetch_only();
    step();
    if_rd_valid = 1'b1;
    if_rd_req   = {32'h0000_0100, 2'd2};
    #1;
    if (mem_rd_valid !== 1'b0) $display("FAIL fetch_c0_valid got=%0h exp=0", mem_rd_valid); else n_pass++;
    n_checks++;
    for (int c = 1; c <= 3; c++) begin
      step();
      if (mem_rd_valid !== 1'b1) $display("FAIL fetch_c%0d_valid got=%0h exp=1", c, mem_rd_valid); else n_pass++;
      n_checks++;
      if (if_rd_rsp !== 33'h0) $display("FAIL fetch_c%0d_rsp got=%0h exp=0", c, if_rd_rsp); else n_pass++;
      n_checks++;
    end
    if (mem_rd_req !== {32'h0000_0100, 2'd2}) $display("FAIL fetch_req got=%0h exp=%0h", mem_rd_req, {32'h0000_0100, 2'd2}); else n_pass++;
    n_checks++;
    step();
    mem_rd_rsp = {32'hDEAD_BEEF, 1'b1};
    #1;
    if (if_rd_rsp !== {32'hDEAD_BEEF, 1'b1}) $display("FAIL fetch_rsp got=%0h exp=%0h", if_rd_rsp, {32'hDEAD_BEEF, 1'b1}); else n_pass++;
    n_checks++;
    if (dm_rd_rsp !== 33'h0) $display("FAIL fetch_dm_rsp_gated got=%0h exp=0", dm_rd_rsp); else n_pass++;
    n_checks++;
    step();
    mem_rd_rsp  = '0;
    if_rd_valid = 1'b0;
    #1;
    if ({busy, mem_rd_valid} !== 2'b00) $display("FAIL fetch_c5_idle got=%0h exp=0", {busy, mem_rd_valid}); else n_pass++;
    n_checks++;
    // Done arrived in the 4th busy cycle, coinciding with the watchdog limit.
    if (timeout_err !== 1'b0) $display("FAIL fetch_done_at_limit_err got=%0h exp=0", timeout_err); else n_pass++;
    n_checks++;
  endtask

  task automatic test_conflict();
    do_reset();
    if_rd_valid = 1'b1;
    if_rd_req   = {32'h0000_0100, 2'd2};
    dm_rd_valid = 1'b1;
    dm_rd_req   = {32'h0000_0400, 2'd2};
    step();
    if (mem_rd_req !== {32'h0000_0100, 2'd2}) $display("FAIL conflict_first_fetch got=%0h exp=%0h", mem_rd_req, {32'h0000_0100, 2'd2}); else n_pass++;
    n_checks++;
    step();
    mem_rd_rsp = {32'hA5A5_0001, 1'b1};
    #1;
    if (if_rd_rsp !== {32'hA5A5_0001, 1'b1}) $display("FAIL conflict_fetch_rsp got=%0h exp=%0h", if_rd_rsp, {32'hA5A5_0001, 1'b1}); else n_pass++;
    n_checks++;
    if (dm_rd_rsp !== 33'h0) $display("FAIL conflict_dm_gated got=%0h exp=0", dm_rd_rsp); else n_pass++;
    n_checks++;
    step();
    // Fetch keeps valid high: a new request that now conflicts with data.
    mem_rd_rsp = '0;
    if_rd_req  = {32'h0000_0104, 2'd2};
    #1;
    if ({busy, mem_rd_valid} !== 2'b00) $display("FAIL conflict_gap_idle got=%0h exp=0", {busy, mem_rd_valid}); else n_pass++;
    n_checks++;
    step();
    if ({mem_rd_valid, mem_rd_req} !== {1'b1, 32'h0000_0400, 2'd2}) $display("FAIL conflict_data_m2 got=%0h exp=%0h", {mem_rd_valid, mem_rd_req}, {1'b1, 32'h0000_0400, 2'd2}); else n_pass++;
    n_checks++;
    mem_rd_rsp = {32'h0BAD_F00D, 1'b1};
    #1;
    if (dm_rd_rsp !== {32'h0BAD_F00D, 1'b1}) $display("FAIL conflict_dm_rsp got=%0h exp=%0h", dm_rd_rsp, {32'h0BAD_F00D, 1'b1}); else n_pass++;
    n_checks++;
    if (if_rd_rsp !== 33'h0) $display("FAIL conflict_if_gated got=%0h exp=0", if_rd_rsp); else n_pass++;
    n_checks++;
    step();
    mem_rd_rsp  = '0;
    dm_rd_valid = 1'b0;
    step();
    if (mem_rd_req !== {32'h0000_0104, 2'd2}) $display("FAIL conflict_fetch_again got=%0h exp=%0h", mem_rd_req, {32'h0000_0104, 2'd2}); else n_pass++;
    n_checks++;
    mem_rd_rsp = {32'hCAFE_0002, 1'b1};
    #1;
    if (if_rd_rsp !== {32'hCAFE_0002, 1'b1}) $display("FAIL conflict_fetch2_rsp got=%0h exp=%0h", if_rd_rsp, {32'hCAFE_0002, 1'b1}); else n_pass++;
    n_checks++;
    step();
    mem_rd_rsp  = '0;
    if_rd_valid = 1'b0;
  endtask

  task automatic test_write_priority();
    step();
    dm_wr_req   = {32'h0000_2000, 2'd2, 32'h1234_5678, 1'b1};
    dm_rd_valid = 1'b1;
    dm_rd_req   = {32'h0000_3000, 2'd2};
    step();
    if (mem_wr_req !== {32'h0000_2000, 2'd2, 32'h1234_5678, 1'b1}) $display("FAIL wr_req got=%0h exp=%0h", mem_wr_req, {32'h0000_2000, 2'd2, 32'h1234_5678, 1'b1}); else n_pass++;
    n_checks++;
    if (mem_rd_valid !== 1'b0) $display("FAIL wr_rd_excl_c1 got=%0h exp=0", mem_rd_valid); else n_pass++;
    n_checks++;
    step();
    mem_wr_rsp = 1'b1;
    #1;
    if ({dm_wr_rsp, dm_rd_rsp} !== {1'b1, 33'h0}) $display("FAIL wr_done got=%0h exp=%0h", {dm_wr_rsp, dm_rd_rsp}, {1'b1, 33'h0}); else n_pass++;
    n_checks++;
    step();
    mem_wr_rsp = 1'b0;
    dm_wr_req  = '0;
    #1;
    if ({mem_wr_req[0], mem_rd_valid} !== 2'b00) $display("FAIL wr_gap_idle got=%0h exp=0", {mem_wr_req[0], mem_rd_valid}); else n_pass++;
    n_checks++;
    step();
    if ({mem_wr_req[0], mem_rd_valid, mem_rd_req} !== {1'b0, 1'b1, 32'h0000_3000, 2'd2}) $display("FAIL wr_then_rd got=%0h exp=%0h", {mem_wr_req[0], mem_rd_valid, mem_rd_req}, {1'b0, 1'b1, 32'h0000_3000, 2'd2}); else n_pass++;
    n_checks++;
    mem_rd_rsp = {32'h55AA_55AA, 1'b1};
    #1;
    if (dm_rd_rsp !== {32'h55AA_55AA, 1'b1}) $display("FAIL wr_then_rd_rsp got=%0h exp=%0h", dm_rd_rsp, {32'h55AA_55AA, 1'b1}); else n_pass++;
    n_checks++;
    step();
    mem_rd_rsp  = '0;
    dm_rd_valid = 1'b0;
  endtask

  task automatic test_timeout();
    step();
    dm_rd_valid = 1'b1;
    dm_rd_req   = {32'h0000_4000, 2'd0};
    for (int c = 1; c <= 3; c++) begin
      step();
      if ({dm_rd_rsp, mem_rd_valid, timeout_err} !== {33'h0, 1'b1, 1'b0}) $display("FAIL to_wait_c%0d got=%0h exp=%0h", c, {dm_rd_rsp, mem_rd_valid, timeout_err}, {33'h0, 1'b1, 1'b0}); else n_pass++;
      n_checks++;
    end
    step();
    if (dm_rd_rsp !== 33'h1) $display("FAIL to_abort_rsp got=%0h exp=1", dm_rd_rsp); else n_pass++;
    n_checks++;
    step();
    dm_rd_valid = 1'b0;
    #1;
    if ({busy, mem_rd_valid, timeout_err} !== 3'b001) $display("FAIL to_after got=%0h exp=1", {busy, mem_rd_valid, timeout_err}); else n_pass++;
    n_checks++;
    if_rd_valid = 1'b1;
    if_rd_req   = {32'h0000_0200, 2'd2};
    step();
    step();
    mem_rd_rsp = {32'h0000_0077, 1'b1};
    #1;
    if (if_rd_rsp !== {32'h0000_0077, 1'b1}) $display("FAIL to_next_rsp got=%0h exp=%0h", if_rd_rsp, {32'h0000_0077, 1'b1}); else n_pass++;
    n_checks++;
    step();
    mem_rd_rsp  = '0;
    if_rd_valid = 1'b0;
    #1;
    if ({busy, timeout_err} !== 2'b01) $display("FAIL to_sticky got=%0h exp=1", {busy, timeout_err}); else n_pass++;
    n_checks++;
  endtask

  task automatic test_reset_mid_write();
    step();
    dm_wr_req = {32'h0000_2100, 2'd2, 32'hFEED_FACE, 1'b1};
    step();
    if (mem_wr_req[0] !== 1'b1) $display("FAIL rmw_wr_en got=%0h exp=1", mem_wr_req[0]); else n_pass++;
    n_checks++;
    step();
    rst_n = 1'b0;
    #1;
    if ({busy, mem_rd_valid, timeout_err} !== 3'b000) $display("FAIL rmw_async_flags got=%0h exp=0", {busy, mem_rd_valid, timeout_err}); else n_pass++;
    n_checks++;
    if (mem_wr_req !== 67'h0) $display("FAIL rmw_async_wr got=%0h exp=0", mem_wr_req); else n_pass++;
    n_checks++;
    mem_wr_rsp = 1'b1;
    #1;
    if (dm_wr_rsp !== 1'b0) $display("FAIL rmw_no_done got=%0h exp=0", dm_wr_rsp); else n_pass++;
    n_checks++;
    clear_inputs();
    step();
    step();
    rst_n = 1'b1;
    step();
    if_rd_valid = 1'b1;
    if_rd_req   = {32'h0000_0300, 2'd1};
    step();
    if ({mem_rd_valid, mem_rd_req} !== {1'b1, 32'h0000_0300, 2'd1}) $display("FAIL rmw_fresh_req got=%0h exp=%0h", {mem_rd_valid, mem_rd_req}, {1'b1, 32'h0000_0300, 2'd1}); else n_pass++;
    n_checks++;
    step();
    mem_rd_rsp = {32'h0000_0099, 1'b1};
    #1;
    if (if_rd_rsp !== {32'h0000_0099, 1'b1}) $display("FAIL rmw_fresh_rsp got=%0h exp=%0h", if_rd_rsp, {32'h0000_0099, 1'b1}); else n_pass++;
    n_checks++;
    step();
    mem_rd_rsp  = '0;
    if_rd_valid = 1'b0;
    #1;
    if (busy !== 1'b0) $display("FAIL rmw_fresh_idle got=%0h exp=0", busy); else n_pass++;
    n_checks++;
  endtask

  task automatic test_spurious();
    step();
    mem_rd_rsp = {32'h1111_2222, 1'b1};
    mem_wr_rsp = 1'b1;
    #1;
    if ({if_rd_rsp, dm_rd_rsp, dm_wr_rsp} !== 67'h0) $display("FAIL spur_idle_rsps got=%0h exp=0", {if_rd_rsp, dm_rd_rsp, dm_wr_rsp}); else n_pass++;
    n_checks++;
    step();
    mem_rd_rsp = '0;
    mem_wr_rsp = 1'b0;
    #1;
    if (busy !== 1'b0) $display("FAIL spur_idle_state got=%0h exp=0", busy); else n_pass++;
    n_checks++;
    if_rd_valid = 1'b1;
    if_rd_req   = {32'h0000_0500, 2'd2};
    step();
    mem_wr_rsp = 1'b1;
    #1;
    if ({dm_wr_rsp, if_rd_rsp} !== 34'h0) $display("FAIL spur_wrong_type_rsp got=%0h exp=0", {dm_wr_rsp, if_rd_rsp}); else n_pass++;
    n_checks++;
    step();
    mem_wr_rsp = 1'b0;
    #1;
    if ({busy, mem_rd_valid} !== 2'b11) $display("FAIL spur_state_kept got=%0h exp=3", {busy, mem_rd_valid}); else n_pass++;
    n_checks++;
    mem_rd_rsp = {32'h3333_4444, 1'b1};
    #1;
    if (if_rd_rsp !== {32'h3333_4444, 1'b1}) $display("FAIL spur_real_done got=%0h exp=%0h", if_rd_rsp, {32'h3333_4444, 1'b1}); else n_pass++;
    n_checks++;
    step();
    mem_rd_rsp  = '0;
    if_rd_valid = 1'b0;
    #1;
    if (busy !== 1'b0) $display("FAIL spur_end_idle got=%0h exp=0", busy); else n_pass++;
    n_checks++;
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_conflict();
    test_write_priority();
    test_timeout();
    test_reset_mid_write();
    test_spurious();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL sim_time_limit got=expired exp=finished");
    $fatal(1, "time limit");
  end

endmodule
